// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared pixel types and defaults for the frame capture path
//
// Purpose: RGB444 word type, default active-area size, capture FSM state enum
// and the colour-reduction helper used by frame_sink.
// Ports: none (package).

package pixel_pkg;

  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    CAPTURE  = 2'd1,
    DRAIN    = 2'd2
  } sink_state_t;

  // Takes the upper nibble of each 8-bit channel.
  function automatic rgb444_t to_rgb444(input logic [3:0] r_hi,
                                        input logic [3:0] g_hi,
                                        input logic [3:0] b_hi);
    rgb444_t px;
    px.r = r_hi;
    px.g = g_hi;
    px.b = b_hi;
    return px;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous first-word-fall-through FIFO
//
// Purpose: holds address+colour words between the capture FSM and the writer.
// The head word is presented on data_o whenever empty_o is low.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (discards contents)
//   push_i, data_i    write request and word; accepted when not full, or when
//                     full and a pop happens in the same cycle
//   pop_i             consume head word (ignored when empty)
//   data_o            head word
//   full_o, empty_o   occupancy flags
//   count_o           number of stored words

module pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNTW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/frame_sink.sv
// rtl/frame_sink.sv - pixel stream capture into framebuffer write words
//
// Purpose: registers sx/sy/de/rgb, reduces colour to RGB444, forms the linear
// address sy*H_RES+sx and queues address+data words for a memory writer.
// A WAIT_SOF/CAPTURE/DRAIN state machine tracks frame boundaries, pulses
// frame_done_out after the last word of a frame leaves, and counts drops.
// Optional feature macro FRAME_SINK_SUM_EN: 16-bit checksum of transferred
// words on frame_sum_out; when undefined frame_sum_out is constant 0.
// Ports:
//   clk_in, rst_in              pixel clock, synchronous active-high reset
//   sx_in, sy_in, de_in         screen position and data enable
//   r_in, g_in, b_in            8-bit colour
//   wr_valid_out, wr_ready_in   write word handshake
//   wr_addr_out, wr_data_out    framebuffer address, RGB444 {r,g,b}
//   frame_done_out              one-cycle pulse after last word of a frame
//   frame_err_out               sticky per frame: drop or early SOF
//   drop_count_out              saturating dropped-pixel count
//   frame_sum_out               frame checksum (see macro above)

module frame_sink
  import pixel_pkg::*;
#(
  parameter int CORDW      = 10,
  parameter int H_RES      = DEF_H_RES,
  parameter int V_RES      = DEF_V_RES,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDRW      = $clog2(H_RES * V_RES)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [CORDW-1:0] sx_in,
  input  logic [CORDW-1:0] sy_in,
  input  logic             de_in,
  input  logic [7:0]       r_in,
  input  logic [7:0]       g_in,
  input  logic [7:0]       b_in,
  output logic             wr_valid_out,
  input  logic             wr_ready_in,
  output logic [ADDRW-1:0] wr_addr_out,
  output logic [11:0]      wr_data_out,
  output logic             frame_done_out,
  output logic             frame_err_out,
  output logic [15:0]      drop_count_out,
  output logic [15:0]      frame_sum_out
);

  localparam int WORDW = ADDRW + 12;
  localparam int CNTW  = $clog2(FIFO_DEPTH) + 1;

  // Input stage
  logic [CORDW-1:0] sx_q, sy_q;
  logic             de_q;
  rgb444_t          pix_q;
  logic             unused_lsbs;

  assign unused_lsbs = ^{r_in[3:0], g_in[3:0], b_in[3:0]};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sx_q  <= '0;
      sy_q  <= '0;
      de_q  <= 1'b0;
      pix_q <= '0;
    end else begin
      sx_q  <= sx_in;
      sy_q  <= sy_in;
      de_q  <= de_in;
      pix_q <= to_rgb444(r_in[7:4], g_in[7:4], b_in[7:4]);
    end
  end

  logic [ADDRW-1:0] pix_addr;
  logic             sof, eof;

  assign pix_addr = ADDRW'(sy_q) * ADDRW'(H_RES) + ADDRW'(sx_q);
  assign sof = de_q && (sx_q == '0) && (sy_q == '0);
  assign eof = de_q && (sx_q == CORDW'(H_RES - 1)) && (sy_q == CORDW'(V_RES - 1));

  // FIFO
  logic             push_req, pop, fifo_full, fifo_empty;
  logic [WORDW-1:0] fifo_dout;
  logic [CNTW-1:0]  fifo_count;

  pixel_fifo #(
    .WIDTH (WORDW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (push_req),
    .data_i  ({pix_addr, pix_q}),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign wr_valid_out = !fifo_empty;
  assign pop          = wr_valid_out && wr_ready_in;
  assign wr_addr_out  = fifo_dout[WORDW-1:12];
  assign wr_data_out  = fifo_dout[11:0];

  // Capture FSM
  sink_state_t state_q, state_d;
  logic        restart, err_set, done_d, last_pop, drop;
  logic        done_q, err_q;
  logic [15:0] drop_q;

  assign last_pop = pop && (fifo_count == CNTW'(1));
  // A push lost to a full FIFO that is not also being popped.
  assign drop     = push_req && fifo_full && !pop;

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    restart  = 1'b0;
    err_set  = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      WAIT_SOF: begin
        if (sof) begin
          push_req = 1'b1;
          restart  = 1'b1;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (sof) begin
          // Early SOF: restart counters, keep words already queued.
          push_req = 1'b1;
          restart  = 1'b1;
          err_set  = 1'b1;
        end else if (de_q) begin
          push_req = 1'b1;
          if (eof) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Done is registered so it appears the cycle after the final transfer.
        if (last_pop || fifo_empty) begin
          done_d  = 1'b1;
          state_d = WAIT_SOF;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= WAIT_SOF;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (restart) begin
        drop_q <= drop ? 16'd1 : 16'd0;
        err_q  <= err_set || drop;
      end else if (drop) begin
        err_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign frame_done_out = done_q;
  assign frame_err_out  = err_q;
  assign drop_count_out = drop_q;

`ifdef FRAME_SINK_SUM_EN
  logic [15:0] sum_q, sum_out_q, sum_next;

  assign sum_next = sum_q + (pop ? {4'd0, wr_data_out} : 16'd0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sum_q     <= '0;
      sum_out_q <= '0;
    end else begin
      sum_q <= restart ? 16'd0 : sum_next;
      if (done_d) sum_out_q <= sum_next;
    end
  end

  assign frame_sum_out = sum_out_q;
`else
  assign frame_sum_out = 16'd0;
`endif

endmodule
